// File: rtl/add_sub_pkg.sv
// ----------------------------------------------------------------------------
// add_sub_pkg: shared types and saturation constants for add_sub_pipe.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package add_sub_pkg;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] a;
    logic [MAX_WIDTH-1:0] b;
    logic                 sub;
    logic                 sat;
  } add_sub_op_t;

  // Largest positive two's-complement value of the given width, zero-extended.
  function automatic logic [MAX_WIDTH-1:0] smax(input int width);
    return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width + 1);
  endfunction

  function automatic logic [MAX_WIDTH-1:0] smin(input int width);
    return {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (width - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_sub_slice.sv
// ----------------------------------------------------------------------------
// add_sub_slice: combinational SW-bit ripple adder built from full_adder cells.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module add_sub_slice
  import add_sub_pkg::*;
#(
  parameter int SW = 4
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] b_i,
  input  logic          cin_i,
  output logic [SW-1:0] sum_o,
  output logic          cout_o
);

  logic [SW:0] w_c;

  assign w_c[0] = cin_i;

  for (genvar i = 0; i < SW; i++) begin : g_bit
    full_adder u_fa (
      .a_i   (a_i[i]),
      .b_i   (b_i[i]),
      .cin_i (w_c[i]),
      .sum_o (sum_o[i]),
      .cout_o(w_c[i+1])
    );
  end

  assign cout_o = w_c[SW];

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder: single-bit full adder cell.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

`default_nettype wire

// File: rtl/add_sub_pipe.sv
// ----------------------------------------------------------------------------
// add_sub_pipe: carry-sliced pipelined add/sub with flags, saturation, valid/ready.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module add_sub_pipe
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] C_SMAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] C_SMIN = WIDTH'(smin(WIDTH));

  logic              w_adv;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              sub_q;
  logic [STAGES-1:0] sat_q;
  logic [STAGES:0]   vld_q;
  logic [STAGES:0]   w_cin;
  logic [WIDTH-1:0]  w_pre;
  logic              w_a_msb;
  logic              w_b_msb;
  logic              ovf_d;
  logic [WIDTH-1:0]  sum_d;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic              ovf_q;
  logic              zero_q;

  // One global enable: the whole pipe freezes while a result waits unconsumed.
  assign w_adv    = !vld_q[STAGES] || out_ready;
  assign in_ready = w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      sat_q <= '0;
      vld_q <= '0;
    end else if (w_adv) begin
      a_q      <= a;
      b_q      <= b ^ {WIDTH{sub}};
      sub_q    <= sub;
      sat_q[0] <= sat;
      vld_q[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) sat_q[i] <= sat_q[i-1];
      for (int i = 1; i <= STAGES; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign w_cin[0] = sub_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0] w_a_s;
    logic [SW-1:0] w_b_s;
    logic [SW-1:0] w_s;
    logic          w_co;

    if (k == 0) begin : g_noskew
      assign w_a_s = a_q[k*SW +: SW];
      assign w_b_s = b_q[k*SW +: SW];
    end else begin : g_skew
      // Slice k waits k cycles so it meets the carry out of slice k-1.
      logic [SW-1:0] a_sk_q [k];
      logic [SW-1:0] b_sk_q [k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            a_sk_q[j] <= '0;
            b_sk_q[j] <= '0;
          end
        end else if (w_adv) begin
          a_sk_q[0] <= a_q[k*SW +: SW];
          b_sk_q[0] <= b_q[k*SW +: SW];
          for (int j = 1; j < k; j++) begin
            a_sk_q[j] <= a_sk_q[j-1];
            b_sk_q[j] <= b_sk_q[j-1];
          end
        end
      end

      assign w_a_s = a_sk_q[k-1];
      assign w_b_s = b_sk_q[k-1];
    end

    add_sub_slice #(.SW(SW)) u_slice (
      .a_i   (w_a_s),
      .b_i   (w_b_s),
      .cin_i (w_cin[k]),
      .sum_o (w_s),
      .cout_o(w_co)
    );

    if (k == STAGES - 1) begin : g_last
      assign w_cin[k+1]          = w_co;
      assign w_pre[k*SW +: SW]   = w_s;
      assign w_a_msb             = w_a_s[SW-1];
      assign w_b_msb             = w_b_s[SW-1];
    end else begin : g_mid
      logic          cy_q;
      logic [SW-1:0] res_q [STAGES-1-k];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cy_q <= 1'b0;
          for (int j = 0; j < STAGES - 1 - k; j++) res_q[j] <= '0;
        end else if (w_adv) begin
          cy_q     <= w_co;
          res_q[0] <= w_s;
          for (int j = 1; j < STAGES - 1 - k; j++) res_q[j] <= res_q[j-1];
        end
      end

      assign w_cin[k+1]        = cy_q;
      assign w_pre[k*SW +: SW] = res_q[STAGES-2-k];
    end
  end

  assign ovf_d = (w_a_msb == w_b_msb) && (w_pre[WIDTH-1] != w_a_msb);
  assign sum_d = (sat_q[STAGES-1] && ovf_d) ? (w_a_msb ? C_SMIN : C_SMAX) : w_pre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (w_adv) begin
      sum_q   <= sum_d;
      carry_q <= w_cin[STAGES];
      ovf_q   <= ovf_d;
      zero_q  <= (sum_d == '0);
    end
  end

  assign out_valid = vld_q[STAGES];
  assign sum       = sum_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire
